// File: rtl/dma_channel_regfile.sv
// Per-channel DMA register file: base/current address and count, mode, mask and TC status.
// CPU reads return one cycle after the access; transfer steps update the current registers each cycle.
module dma_channel_regfile #(
  parameter int CHANNELS     = 4,
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 2 * DATAWIDTH,
  localparam int CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    CS_N,
  input  logic                    IOR_N,
  input  logic                    IOW_N,
  input  logic [CHW-1:0]          REG_CH,
  input  logic [1:0]              REG_FN,
  input  logic [DATAWIDTH-1:0]    DB_IN,
  output logic [DATAWIDTH-1:0]    DB_OUT,
  output logic                    DB_OE,
  input  logic                    XFER_STEP,
  input  logic [CHW-1:0]          XFER_CH,
  output logic [ADDRESSWIDTH-1:0] CUR_ADDR,
  output logic                    TC,
  output logic [CHANNELS-1:0]     CH_MASK
);

  localparam logic [ADDRESSWIDTH-1:0] ONE = ADDRESSWIDTH'(1);

  logic [ADDRESSWIDTH-1:0] baseAddr [CHANNELS];
  logic [ADDRESSWIDTH-1:0] curAddr  [CHANNELS];
  logic [ADDRESSWIDTH-1:0] baseCnt  [CHANNELS];
  logic [ADDRESSWIDTH-1:0] curCnt   [CHANNELS];
  logic [CHANNELS-1:0]     autoInit;
  logic [CHANNELS-1:0]     decMode;
  logic [CHANNELS-1:0]     tcStatus;
  logic                    bytePtr;

  logic                    wrAcc;
  logic                    rdAcc;
  logic                    ptrFn;
  logic [CHANNELS-1:0]     stepHit;
  logic [CHANNELS-1:0]     tcHit;
  logic [DATAWIDTH-1:0]    rdData;

  always_comb begin
    wrAcc    = ~CS_N & ~IOW_N & IOR_N;
    rdAcc    = ~CS_N & ~IOR_N & IOW_N;
    ptrFn    = ~REG_FN[1];
    stepHit  = '0;
    tcHit    = '0;
    rdData   = '0;
    CUR_ADDR = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // A CPU address/count write to the stepping channel wins; the step is lost.
      stepHit[i] = XFER_STEP && (XFER_CH == CHW'(i)) && !CH_MASK[i] &&
                   !(wrAcc && ptrFn && (REG_CH == CHW'(i)));
      tcHit[i]   = stepHit[i] && (curCnt[i] == '0);
      if (XFER_CH == CHW'(i)) CUR_ADDR = curAddr[i];
      if (REG_CH == CHW'(i)) begin
        case (REG_FN)
          2'b00: rdData = bytePtr ? curAddr[i][ADDRESSWIDTH-1:DATAWIDTH] : curAddr[i][DATAWIDTH-1:0];
          2'b01: rdData = bytePtr ? curCnt[i][ADDRESSWIDTH-1:DATAWIDTH]  : curCnt[i][DATAWIDTH-1:0];
          2'b10: rdData[1:0] = {decMode[i], autoInit[i]};
          default: ;
        endcase
      end
    end
    if (REG_FN == 2'b11) rdData[CHANNELS-1:0] = tcStatus;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < CHANNELS; i++) begin
        baseAddr[i] <= '0;
        curAddr[i]  <= '0;
        baseCnt[i]  <= '0;
        curCnt[i]   <= '0;
      end
      autoInit <= '0;
      decMode  <= '0;
      tcStatus <= '0;
      CH_MASK  <= '0;
      bytePtr  <= 1'b0;
      DB_OUT   <= '0;
      DB_OE    <= 1'b0;
      TC       <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wrAcc && (REG_CH == CHW'(i)) && (REG_FN == 2'b00)) begin
          if (bytePtr) begin
            baseAddr[i][ADDRESSWIDTH-1:DATAWIDTH] <= DB_IN;
            curAddr[i][ADDRESSWIDTH-1:DATAWIDTH]  <= DB_IN;
          end else begin
            baseAddr[i][DATAWIDTH-1:0] <= DB_IN;
            curAddr[i][DATAWIDTH-1:0]  <= DB_IN;
          end
        end else if (stepHit[i]) begin
          if (tcHit[i] && autoInit[i]) curAddr[i] <= baseAddr[i];
          else if (decMode[i])         curAddr[i] <= curAddr[i] - ONE;
          else                         curAddr[i] <= curAddr[i] + ONE;
        end

        if (wrAcc && (REG_CH == CHW'(i)) && (REG_FN == 2'b01)) begin
          if (bytePtr) begin
            baseCnt[i][ADDRESSWIDTH-1:DATAWIDTH] <= DB_IN;
            curCnt[i][ADDRESSWIDTH-1:DATAWIDTH]  <= DB_IN;
          end else begin
            baseCnt[i][DATAWIDTH-1:0] <= DB_IN;
            curCnt[i][DATAWIDTH-1:0]  <= DB_IN;
          end
        end else if (stepHit[i]) begin
          if (tcHit[i] && autoInit[i]) curCnt[i] <= baseCnt[i];
          else                         curCnt[i] <= curCnt[i] - ONE;
        end

        if (wrAcc && (REG_CH == CHW'(i)) && (REG_FN == 2'b10)) begin
          autoInit[i] <= DB_IN[0];
          decMode[i]  <= DB_IN[1];
        end

        // Finishing the high count byte arms the channel.
        if (wrAcc && (REG_CH == CHW'(i)) && (REG_FN == 2'b01) && bytePtr)
          CH_MASK[i] <= 1'b0;
        else if ((wrAcc && (REG_CH == CHW'(i)) && (REG_FN == 2'b11) && DB_IN[1]) ||
                 (tcHit[i] && !autoInit[i]))
          CH_MASK[i] <= 1'b1;
      end

      tcStatus <= ((rdAcc && (REG_FN == 2'b11)) ? '0 : tcStatus) | tcHit;

      if (wrAcc && (REG_FN == 2'b11) && DB_IN[0]) bytePtr <= 1'b0;
      else if ((wrAcc || rdAcc) && ptrFn)         bytePtr <= ~bytePtr;

      DB_OE <= rdAcc;
      if (rdAcc) DB_OUT <= rdData;
      TC <= |tcHit;
    end
  end

endmodule

// File: tb/tb_dma_channel_regfile.sv
// Randomized and directed bench for dma_channel_regfile against a transaction-level reference model.
module tb_dma_channel_regfile;

  logic        clk;
  logic        resetN;
  logic        csN;
  logic        iorN;
  logic        iowN;
  logic [1:0]  regCh;
  logic [1:0]  regFn;
  logic [7:0]  dbIn;
  logic [7:0]  dbOut;
  logic        dbOe;
  logic        xferStep;
  logic [1:0]  xferCh;
  logic [15:0] curAddr;
  logic        tc;
  logic [3:0]  chMask;

  dma_channel_regfile dut (
    .CLK(clk), .RESET_N(resetN), .CS_N(csN), .IOR_N(iorN), .IOW_N(iowN),
    .REG_CH(regCh), .REG_FN(regFn), .DB_IN(dbIn), .DB_OUT(dbOut), .DB_OE(dbOe),
    .XFER_STEP(xferStep), .XFER_CH(xferCh), .CUR_ADDR(curAddr), .TC(tc), .CH_MASK(chMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // reference model: per-channel values as plain integers
  int mBaseA[4], mCurA[4], mBaseC[4], mCurC[4];
  bit mAuto[4], mDec[4], mMask[4], mTcs[4];
  bit mPtr;
  int eOut;
  bit eOe, eTc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mReset();
    for (int i = 0; i < 4; i++) begin
      mBaseA[i] = 0; mCurA[i] = 0; mBaseC[i] = 0; mCurC[i] = 0;
      mAuto[i] = 0; mDec[i] = 0; mMask[i] = 0; mTcs[i] = 0;
    end
    mPtr = 0; eOut = 0; eOe = 0; eTc = 0;
  endtask

  function automatic int setByte(input int word, input bit hi, input int b);
    return hi ? ((word & 'h00FF) | (b << 8)) : ((word & 'hFF00) | b);
  endfunction

  function automatic int readVal(input int c, input int fn);
    int v = 0;
    case (fn)
      0: v = mPtr ? (mCurA[c] >> 8) : (mCurA[c] & 'hFF);
      1: v = mPtr ? (mCurC[c] >> 8) : (mCurC[c] & 'hFF);
      2: v = mDec[c] * 2 + mAuto[c];
      default: for (int i = 0; i < 4; i++) v += mTcs[i] << i;
    endcase
    return v;
  endfunction

  // Apply one clock edge's worth of CPU access and transfer step to the model.
  task automatic modelEdge();
    bit wr, rd, stepOk, tcNow, xAuto, xDec;
    int c, x, fn, d;
    wr = !csN && !iowN && iorN;
    rd = !csN && !iorN && iowN;
    c = regCh; x = xferCh; fn = regFn; d = dbIn;
    stepOk = xferStep && !mMask[x] && !(wr && fn < 2 && c == x);
    tcNow = stepOk && (mCurC[x] == 0);
    xAuto = mAuto[x]; xDec = mDec[x];
    eOe = rd;
    if (rd) eOut = readVal(c, fn);
    if (rd && fn == 3) for (int i = 0; i < 4; i++) mTcs[i] = 0;
    if (wr) begin
      case (fn)
        0: begin mBaseA[c] = setByte(mBaseA[c], mPtr, d); mCurA[c] = setByte(mCurA[c], mPtr, d); end
        1: begin
             mBaseC[c] = setByte(mBaseC[c], mPtr, d); mCurC[c] = setByte(mCurC[c], mPtr, d);
             if (mPtr) mMask[c] = 0;
           end
        2: begin mAuto[c] = d[0]; mDec[c] = d[1]; end
        default: if (d[1]) mMask[c] = 1;
      endcase
    end
    if (wr && fn == 3 && d[0]) mPtr = 0;
    else if ((wr || rd) && fn < 2) mPtr = !mPtr;
    if (stepOk) begin
      if (tcNow && xAuto) begin
        mCurA[x] = mBaseA[x]; mCurC[x] = mBaseC[x];
      end else begin
        mCurA[x] = (mCurA[x] + (xDec ? 65535 : 1)) % 65536;
        mCurC[x] = (mCurC[x] + 65535) % 65536;
      end
      if (tcNow) begin
        mTcs[x] = 1;
        if (!xAuto) mMask[x] = 1;
      end
    end
    eTc = tcNow;
  endtask

  task automatic compareAll();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = mMask[i];
    chk("db_oe", dbOe, eOe);
    chk("db_out", dbOut, eOut);
    chk("tc", tc, eTc);
    chk("ch_mask", chMask, m);
    chk("cur_addr", curAddr, mCurA[xferCh]);
  endtask

  task automatic idleIn();
    csN = 1; iorN = 1; iowN = 1; xferStep = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1 compareAll();
    idleIn();
  endtask

  task automatic cpuWr(input int ch, input int fn, input int d);
    csN = 0; iowN = 0; iorN = 1; regCh = 2'(ch); regFn = 2'(fn); dbIn = 8'(d);
    tick();
  endtask

  task automatic cpuRd(input int ch, input int fn);
    csN = 0; iorN = 0; iowN = 1; regCh = 2'(ch); regFn = 2'(fn);
    tick();
  endtask

  task automatic step(input int ch);
    xferStep = 1; xferCh = 2'(ch);
    tick();
  endtask

  initial begin
    idleIn();
    regCh = 0; regFn = 0; dbIn = 0; xferCh = 0;
    resetN = 0;
    mReset();
    #12;
    chk("rst_db_out", dbOut, 0);
    chk("rst_db_oe", dbOe, 0);
    chk("rst_tc", tc, 0);
    chk("rst_mask", chMask, 0);
    chk("rst_cur_addr", curAddr, 0);
    resetN = 1;

    // byte-pair write then read back through the shared pointer
    cpuWr(1, 0, 'h34);
    cpuWr(1, 0, 'h12);
    cpuRd(1, 0);
    chk("pair_rd_lo", dbOut, 'h34);
    chk("pair_oe_lo", dbOe, 1);
    cpuRd(1, 0);
    chk("pair_rd_hi", dbOut, 'h12);
    tick();
    chk("pair_oe_drop", dbOe, 0);
    chk("pair_hold", dbOut, 'h12);

    // non-autoinit terminal count on ch0
    cpuWr(0, 3, 'h01);
    cpuWr(0, 1, 'h02); cpuWr(0, 1, 'h00);
    cpuWr(0, 0, 'h00); cpuWr(0, 0, 'h10);
    cpuWr(0, 2, 'h00);
    step(0); step(0);
    chk("tc0_early", tc, 0);
    step(0);
    chk("tc0_pulse", tc, 1);
    chk("tc0_mask", chMask[0], 1);
    step(0);
    chk("tc0_ignored", tc, 0);
    chk("tc0_addr", curAddr, 'h1003);
    cpuRd(0, 1); chk("tc0_cnt_lo", dbOut, 'hFF);
    cpuRd(0, 1); chk("tc0_cnt_hi", dbOut, 'hFF);

    // autoinit decrementing channel reloads on terminal count
    cpuWr(2, 2, 'h03);
    cpuWr(2, 0, 'h00); cpuWr(2, 0, 'h20);
    cpuWr(2, 1, 'h00); cpuWr(2, 1, 'h00);
    step(2);
    chk("tc2_pulse", tc, 1);
    chk("tc2_addr", curAddr, 'h2000);
    chk("tc2_mask", chMask[2], 0);
    cpuRd(2, 1); chk("tc2_cnt_lo", dbOut, 'h00);
    cpuRd(2, 1); chk("tc2_cnt_hi", dbOut, 'h00);

    // status read clears; concurrent TC survives the clear
    cpuRd(0, 3);
    cpuWr(3, 2, 'h00);
    cpuWr(3, 1, 'h00); cpuWr(3, 1, 'h00);
    step(3);
    cpuRd(3, 3);
    chk("sts_tc3", dbOut, 'h08);
    cpuRd(3, 3);
    chk("sts_clear", dbOut, 'h00);
    csN = 0; iorN = 0; iowN = 1; regFn = 3; xferStep = 1; xferCh = 2;
    tick();
    cpuRd(0, 3);
    chk("sts_survive", dbOut, 'h04);

    // CPU count write beats a concurrent step on the same channel
    cpuWr(0, 3, 'h01);
    cpuWr(0, 1, 'h05); cpuWr(0, 1, 'h00);
    csN = 0; iowN = 0; iorN = 1; regCh = 0; regFn = 1; dbIn = 'h09; xferStep = 1; xferCh = 0;
    tick();
    chk("coll_no_tc", tc, 0);
    cpuWr(0, 3, 'h01);
    cpuRd(0, 1);
    chk("coll_cnt", dbOut, 'h09);

    // reset between the two bytes of a pair
    cpuWr(1, 0, 'hAA);
    #2 resetN = 0;
    #1;
    chk("mid_db_out", dbOut, 0);
    chk("mid_tc", tc, 0);
    chk("mid_mask", chMask, 0);
    chk("mid_cur_addr", curAddr, 0);
    mReset();
    #2 resetN = 1;
    cpuWr(1, 0, 'h55);
    cpuWr(1, 0, 'h66);
    cpuRd(1, 0);
    chk("mid_lo_byte", dbOut, 'h55);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      csN  = (kind == 0);
      iowN = (kind == 1) ? 1'b0 : (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      iorN = (kind == 2) ? 1'b0 : (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      regCh = 2'($urandom_range(0, 3));
      regFn = 2'($urandom_range(0, 3));
      dbIn  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      if (regFn == 3 && $urandom_range(0, 3) != 0) dbIn[1] = 1'b0;
      xferStep = 1'($urandom_range(0, 1));
      xferCh   = 2'($urandom_range(0, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
